// File: rtl/scv_romload.sv
// MiSTer ioctl download to scv ROMINIT bus bridge, with system reset hold and load status.
// Optional cartridge checksum is enabled by defining SCV_ROMLOAD_CKSUM_EN.
module scv_romload #(
    parameter logic [7:0]  BIOS_IDX    = 8'd0,
    parameter logic [7:0]  CART_IDX    = 8'd1,
    parameter logic [15:0] HOLD_CYCLES = 16'd1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IOCTL_DOWNLOAD,
    input  logic [7:0]  IOCTL_INDEX,
    input  logic        IOCTL_WR,
    input  logic [7:0]  IOCTL_DOUT,
    output logic        ROMINIT_SEL_BOOT,
    output logic        ROMINIT_SEL_CHR,
    output logic        ROMINIT_SEL_APU,
    output logic        ROMINIT_SEL_CART,
    output logic [24:0] ROMINIT_ADDR,
    output logic [7:0]  ROMINIT_DATA,
    output logic        ROMINIT_VALID,
    output logic        SYS_RESB,
    output logic        BIOS_OK,
    output logic [17:0] CART_BYTES,
    output logic        CART_OVF,
    output logic [15:0] CART_CKSUM
);

    typedef enum logic [2:0] {StIdle, StBios, StCart, StSkip, StHold} state_e;

    localparam logic [24:0] ChrBase  = 25'h0001000;
    localparam logic [24:0] ApuBase  = 25'h0001400;
    localparam logic [24:0] BiosEnd  = 25'h0001800;
    localparam logic [24:0] CartSize = 25'h0020000;

    state_e      state_q;
    logic        dl_q;
    logic [24:0] bc_q;
    logic [15:0] hold_q;
    logic        sel_boot_q, sel_chr_q, sel_apu_q, sel_cart_q;
    logic [24:0] addr_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        sys_resb_q;
    logic        bios_ok_q;
    logic [17:0] cart_bytes_q;
    logic        cart_ovf_q;
`ifdef SCV_ROMLOAD_CKSUM_EN
    logic [15:0] cksum_q;
`endif

    logic        dl_rise, dl_fall, in_load, accept;
    logic [24:0] bc_inc;

    assign dl_rise = IOCTL_DOWNLOAD & ~dl_q;
    assign dl_fall = ~IOCTL_DOWNLOAD & dl_q;
    assign in_load = (state_q == StBios) || (state_q == StCart) || (state_q == StSkip);
    assign accept  = IOCTL_DOWNLOAD & IOCTL_WR & in_load;
    assign bc_inc  = (bc_q == 25'h1FFFFFF) ? bc_q : bc_q + 25'd1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= StIdle;
            // Reset high so a download already active at reset release is not restarted
            dl_q         <= 1'b1;
            bc_q         <= '0;
            hold_q       <= HOLD_CYCLES;
            sel_boot_q   <= 1'b0;
            sel_chr_q    <= 1'b0;
            sel_apu_q    <= 1'b0;
            sel_cart_q   <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            sys_resb_q   <= 1'b0;
            bios_ok_q    <= 1'b0;
            cart_bytes_q <= '0;
            cart_ovf_q   <= 1'b0;
`ifdef SCV_ROMLOAD_CKSUM_EN
            cksum_q      <= '0;
`endif
        end else begin
            dl_q    <= IOCTL_DOWNLOAD;
            valid_q <= 1'b0;
            case (state_q)
                StIdle, StHold: begin
                    if (dl_rise) begin
                        bc_q       <= '0;
                        sys_resb_q <= 1'b0;
                        if (IOCTL_INDEX == BIOS_IDX) begin
                            state_q   <= StBios;
                            bios_ok_q <= 1'b0;
                        end else if (IOCTL_INDEX == CART_IDX) begin
                            state_q    <= StCart;
                            cart_ovf_q <= 1'b0;
`ifdef SCV_ROMLOAD_CKSUM_EN
                            cksum_q    <= '0;
`endif
                        end else begin
                            state_q <= StSkip;
                        end
                    end else if (state_q == StHold) begin
                        // HOLD spans max(HOLD_CYCLES, 1) cycles from entry
                        if (hold_q <= 16'd1) begin
                            state_q    <= StIdle;
                            sys_resb_q <= bios_ok_q;
                        end else begin
                            hold_q <= hold_q - 16'd1;
                        end
                    end else begin
                        sys_resb_q <= bios_ok_q;
                    end
                end
                StBios, StCart, StSkip: begin
                    if (dl_fall) begin
                        state_q <= StHold;
                        hold_q  <= HOLD_CYCLES;
                        if (state_q == StBios) begin
                            bios_ok_q <= (bc_q >= BiosEnd);
                        end
                        if (state_q == StCart) begin
                            cart_bytes_q <= (bc_q >= CartSize) ? 18'h20000 : bc_q[17:0];
                        end
                    end else if (accept) begin
                        bc_q <= bc_inc;
                        if (state_q == StBios && bc_q < BiosEnd) begin
                            valid_q    <= 1'b1;
                            data_q     <= IOCTL_DOUT;
                            sel_cart_q <= 1'b0;
                            sel_boot_q <= (bc_q < ChrBase);
                            sel_chr_q  <= (bc_q >= ChrBase) && (bc_q < ApuBase);
                            sel_apu_q  <= (bc_q >= ApuBase);
                            if (bc_q < ChrBase) begin
                                addr_q <= bc_q;
                            end else if (bc_q < ApuBase) begin
                                addr_q <= bc_q - ChrBase;
                            end else begin
                                addr_q <= bc_q - ApuBase;
                            end
                        end else if (state_q == StCart) begin
                            if (bc_q < CartSize) begin
                                valid_q    <= 1'b1;
                                data_q     <= IOCTL_DOUT;
                                addr_q     <= bc_q;
                                sel_boot_q <= 1'b0;
                                sel_chr_q  <= 1'b0;
                                sel_apu_q  <= 1'b0;
                                sel_cart_q <= 1'b1;
`ifdef SCV_ROMLOAD_CKSUM_EN
                                cksum_q    <= cksum_q + {8'h00, IOCTL_DOUT};
`endif
                            end else begin
                                cart_ovf_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ROMINIT_SEL_BOOT = sel_boot_q;
    assign ROMINIT_SEL_CHR  = sel_chr_q;
    assign ROMINIT_SEL_APU  = sel_apu_q;
    assign ROMINIT_SEL_CART = sel_cart_q;
    assign ROMINIT_ADDR     = addr_q;
    assign ROMINIT_DATA     = data_q;
    assign ROMINIT_VALID    = valid_q;
    assign SYS_RESB         = sys_resb_q;
    assign BIOS_OK          = bios_ok_q;
    assign CART_BYTES       = cart_bytes_q;
    assign CART_OVF         = cart_ovf_q;
`ifdef SCV_ROMLOAD_CKSUM_EN
    assign CART_CKSUM       = cksum_q;
`else
    assign CART_CKSUM       = 16'h0000;
`endif

endmodule

// File: tb/tb_scv_romload.sv
// Directed bench for scv_romload: BIOS/cart mapping, overflow, skip, HOLD timing and async reset.
module tb_scv_romload;

    logic        clk = 1'b0;
    logic        rst;
    logic        dl;
    logic [7:0]  idx;
    logic        wr;
    logic [7:0]  dout;
    logic        sel_boot, sel_chr, sel_apu, sel_cart;
    logic [24:0] addr;
    logic [7:0]  data;
    logic        valid, sys_resb, bios_ok, cart_ovf;
    logic [17:0] cart_bytes;
    logic [15:0] cart_cksum;

    int n_checks = 0;
    int n_fail   = 0;

    int n_strobe, n_boot, n_chr, n_apu, n_cart;
    int boot_err, chr_err, apu_err, cart_err, sel_err, lat_err;
    logic [24:0] last_cart_addr, chr0_addr;
    logic [7:0]  chr0_data, apu3ff_data;
    bit lat_on = 1'b0;
    bit wr_prev = 1'b0;
    int cnt;

    always #5 clk = ~clk;

    scv_romload dut (
        .CLK              (clk),
        .RST              (rst),
        .IOCTL_DOWNLOAD   (dl),
        .IOCTL_INDEX      (idx),
        .IOCTL_WR         (wr),
        .IOCTL_DOUT       (dout),
        .ROMINIT_SEL_BOOT (sel_boot),
        .ROMINIT_SEL_CHR  (sel_chr),
        .ROMINIT_SEL_APU  (sel_apu),
        .ROMINIT_SEL_CART (sel_cart),
        .ROMINIT_ADDR     (addr),
        .ROMINIT_DATA     (data),
        .ROMINIT_VALID    (valid),
        .SYS_RESB         (sys_resb),
        .BIOS_OK          (bios_ok),
        .CART_BYTES       (cart_bytes),
        .CART_OVF         (cart_ovf),
        .CART_CKSUM       (cart_cksum)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_tally();
        n_strobe = 0; n_boot = 0; n_chr = 0; n_apu = 0; n_cart = 0;
        boot_err = 0; chr_err = 0; apu_err = 0; cart_err = 0; sel_err = 0; lat_err = 0;
        last_cart_addr = '1; chr0_addr = '1; chr0_data = 8'h5A; apu3ff_data = 8'h5A;
    endtask

    // Strobe monitor: inputs change at posedge+2, outputs are stable at negedge
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            n_strobe++;
            if (int'(sel_boot) + int'(sel_chr) + int'(sel_apu) + int'(sel_cart) != 1) sel_err++;
            if (sel_boot) begin
                if (addr != 25'(n_boot) || data != n_boot[7:0]) boot_err++;
                n_boot++;
            end
            if (sel_chr) begin
                if (n_chr == 0) begin chr0_addr = addr; chr0_data = data; end
                if (addr != 25'(n_chr) || data != n_chr[7:0]) chr_err++;
                n_chr++;
            end
            if (sel_apu) begin
                if (addr == 25'h3FF) apu3ff_data = data;
                if (addr != 25'(n_apu) || data != n_apu[7:0]) apu_err++;
                n_apu++;
            end
            if (sel_cart) begin
                if (addr != 25'(n_cart) || data != 8'h01) cart_err++;
                last_cart_addr = addr;
                n_cart++;
            end
        end
        if (lat_on && (valid !== wr_prev)) lat_err++;
        wr_prev = wr && dl;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_dl(input logic [7:0] i);
        idx = i;
        dl  = 1'b1;
        tick();
    endtask

    task automatic end_dl();
        wr = 1'b0;
        dl = 1'b0;
        tick();
    endtask

    // mode 0: byte = index, back to back; 1: 0x01 with 0-3 idle gaps; 2: 0x01 back to back
    task automatic send_bytes(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            wr   = 1'b1;
            dout = (mode == 0) ? i[7:0] : 8'h01;
            tick();
            wr = 1'b0;
            if (mode == 1) repeat (i % 4) tick();
        end
    endtask

    task automatic wait_resb(input int limit, output int c);
        c = 0;
        while (sys_resb !== 1'b1 && c < limit) begin
            tick();
            c++;
        end
    endtask

    initial begin
        rst = 1'b1; dl = 1'b0; idx = 8'h00; wr = 1'b0; dout = 8'h00;
        clear_tally();
        repeat (3) tick();
        check("rst_valid", valid, 0);
        check("rst_resb", sys_resb, 0);
        check("rst_bios_ok", bios_ok, 0);
        check("rst_addr", addr, 0);
        check("rst_cksum", cart_cksum, 0);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_resb_no_bios", sys_resb, 0);

        // Full BIOS plus 4 extra bytes that must not strobe
        clear_tally();
        start_dl(8'd0);
        send_bytes(32'h1804, 0);
        check("bios_resb_during", sys_resb, 0);
        end_dl();
        check("bios_boot_cnt", n_boot, 4096);
        check("bios_boot_err", boot_err, 0);
        check("bios_chr_cnt", n_chr, 1024);
        check("bios_chr_err", chr_err, 0);
        check("bios_apu_cnt", n_apu, 1024);
        check("bios_apu_err", apu_err, 0);
        check("bios_total", n_strobe, 32'h1800);
        check("bios_sel_onehot", sel_err, 0);
        check("bios_chr0_addr", chr0_addr, 0);
        check("bios_chr0_data", chr0_data, 8'h00);
        check("bios_apu3ff_data", apu3ff_data, 8'hFF);
        check("bios_ok", bios_ok, 1);
        check("bios_resb_hold", sys_resb, 0);
        wait_resb(3000, cnt);
        check("bios_hold_len", cnt, 1024);

        // Cart with write gaps, latency tracked per strobe
        clear_tally();
        start_dl(8'd1);
        lat_on = 1'b1;
        send_bytes(32'h2000, 1);
        end_dl();
        lat_on = 1'b0;
        check("cart_cnt", n_cart, 32'h2000);
        check("cart_err", cart_err, 0);
        check("cart_latency", lat_err, 0);
        check("cart_bytes", cart_bytes, 18'h02000);
        check("cart_ovf", cart_ovf, 0);
`ifdef SCV_ROMLOAD_CKSUM_EN
        check("cart_cksum", cart_cksum, 16'h2000);
`else
        check("cart_cksum", cart_cksum, 16'h0000);
`endif

        // Cart overflow, started during the previous HOLD
        clear_tally();
        start_dl(8'd1);
        send_bytes(32'h20005, 2);
        end_dl();
        check("ovf_cnt", n_cart, 32'h20000);
        check("ovf_err", cart_err, 0);
        check("ovf_last_addr", last_cart_addr, 25'h1FFFF);
        check("ovf_flag", cart_ovf, 1);
        check("ovf_bytes", cart_bytes, 18'h20000);
        check("ovf_cksum", cart_cksum, 16'h0000);

        // Unknown index, then a cart started during HOLD
        clear_tally();
        start_dl(8'd5);
        send_bytes(16, 2);
        end_dl();
        repeat (10) tick();
        check("skip_strobes", n_strobe, 0);
        check("skip_resb", sys_resb, 0);
        check("skip_bytes_kept", cart_bytes, 18'h20000);
        check("skip_ovf_kept", cart_ovf, 1);
        start_dl(8'd1);
        check("hold_cart_ovf_clr", cart_ovf, 0);
        send_bytes(16, 2);
        end_dl();
        check("hold_cart_cnt", n_cart, 16);
        check("hold_cart_err", cart_err, 0);
        check("hold_cart_bytes", cart_bytes, 18'd16);
        wait_resb(3000, cnt);
        check("hold_cart_len", cnt, 1024);

        // Short BIOS
        clear_tally();
        start_dl(8'd0);
        send_bytes(32'h1000, 0);
        end_dl();
        wait_resb(1500, cnt);
        check("short_bios_ok", bios_ok, 0);
        check("short_resb_low", cnt, 1500);
        check("short_chr_cnt", n_chr, 0);

        // Async reset mid-BIOS
        clear_tally();
        start_dl(8'd0);
        send_bytes(100, 0);
        #1 rst = 1'b1;
        #1;
        check("arst_valid", valid, 0);
        check("arst_sel_boot", sel_boot, 0);
        check("arst_addr", addr, 0);
        check("arst_data", data, 0);
        check("arst_resb", sys_resb, 0);
        check("arst_bios_ok", bios_ok, 0);
        check("arst_cart_bytes", cart_bytes, 0);
        tick();
        rst = 1'b0;
        tick();
        clear_tally();
        send_bytes(20, 2);
        check("arst_wr_ignored", n_strobe, 0);
        end_dl();
        start_dl(8'd0);
        send_bytes(4, 0);
        end_dl();
        check("arst_reload_cnt", n_boot, 4);
        check("arst_reload_err", boot_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
